writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter.sv | 93 +++++++++
 tb/tb_writeback_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: round-robin ALU/load writeback arbiter with a one-cycle staging register and a register scoreboard.
// Optional macro WB_BYPASS_EN forwards the staged write to the A/B source queries instead of reporting them busy.
module writeback_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [ADDR_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic [ADDR_WIDTH-1:0] a_address,
    input  logic [ADDR_WIDTH-1:0] b_address,
    output logic                  a_busy,
    output logic                  b_busy,
    output logic                  fwd_a_valid,
    output logic [DATA_WIDTH-1:0] fwd_a_data,
    output logic                  fwd_b_valid,
    output logic [DATA_WIDTH-1:0] fwd_b_data,
    output logic                  rf_write,
    output logic [ADDR_WIDTH-1:0] rf_c_address,
    output logic [DATA_WIDTH-1:0] rf_c_in
);
    localparam int REGS = 2 ** ADDR_WIDTH;
    localparam logic [REGS-1:0] ONE = 1;
`ifdef WB_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif
    logic                  ptr;
    logic                  staged;
    logic [REGS-1:0]       pending;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] xfer_rd;
    logic [DATA_WIDTH-1:0] xfer_data;
    logic [REGS-1:0]       set_mask;
    logic [REGS-1:0]       clr_mask;

    // ptr=1 means the load unit has priority when both request
    always_comb begin
        alu_ready = !reset && alu_valid && (!mem_valid || !ptr);
        mem_ready = !reset && mem_valid && (!alu_valid || ptr);
        xfer      = alu_ready || mem_ready;
        xfer_rd   = alu_ready ? alu_rd : mem_rd;
        xfer_data = alu_ready ? alu_data : mem_data;
        set_mask  = issue_valid ? ONE << issue_rd : '0;
        clr_mask  = xfer ? ONE << xfer_rd : '0;
        rf_write  = staged && !reset;
    end

    always_comb begin
        a_busy = a_address != '0 && (pending[a_address] || (rf_write && rf_c_address == a_address && !BYPASS));
        b_busy = b_address != '0 && (pending[b_address] || (rf_write && rf_c_address == b_address && !BYPASS));
`ifdef WB_BYPASS_EN
        fwd_a_valid = rf_write && rf_c_address == a_address && a_address != '0;
        fwd_b_valid = rf_write && rf_c_address == b_address && b_address != '0;
        fwd_a_data  = rf_c_in;
        fwd_b_data  = rf_c_in;
`else
        fwd_a_valid = 1'b0;
        fwd_b_valid = 1'b0;
        fwd_a_data  = '0;
        fwd_b_data  = '0;
`endif
    end

    // set is ORed in after the clear so an issue wins over a same-cycle writeback
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr          <= 1'b0;
            staged       <= 1'b0;
            pending      <= '0;
            rf_c_address <= '0;
            rf_c_in      <= '0;
        end else begin
            staged  <= xfer && xfer_rd != '0;
            pending <= ((pending & ~clr_mask) | set_mask) & ~ONE;
            if (xfer) begin
                ptr          <= alu_ready;
                rf_c_address <= xfer_rd;
                rf_c_in      <= xfer_data;
            end
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed checks of arbitration, staging, scoreboard and reset behaviour.
module tb_writeback_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0, mem_valid = 1'b0, issue_valid = 1'b0;
    logic        alu_ready, mem_ready, a_busy, b_busy, fwd_a_valid, fwd_b_valid, rf_write;
    logic [4:0]  alu_rd = '0, mem_rd = '0, issue_rd = '0, a_address = '0, b_address = '0, rf_c_address;
    logic [31:0] alu_data = '0, mem_data = '0, fwd_a_data, fwd_b_data, rf_c_in;
    int          total = 0;
    int          passed = 0;
`ifdef WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    writeback_arbiter dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .a_address(a_address), .b_address(b_address), .a_busy(a_busy), .b_busy(b_busy),
        .fwd_a_valid(fwd_a_valid), .fwd_a_data(fwd_a_data),
        .fwd_b_valid(fwd_b_valid), .fwd_b_data(fwd_b_data),
        .rf_write(rf_write), .rf_c_address(rf_c_address), .rf_c_in(rf_c_in)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        alu_valid = 1'b1;
        mem_valid = 1'b1;
        #1;
        check("rst_alu_ready", 32'(alu_ready), 0);
        check("rst_mem_ready", 32'(mem_ready), 0);
        step();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        step();
        check("rst_rf_write", 32'(rf_write), 0);
        check("rst_rf_addr", 32'(rf_c_address), 0);
        check("rst_rf_in", rf_c_in, 0);
        check("rst_fwd_a", 32'(fwd_a_valid), 0);
        reset = 1'b0;
        alu_valid = 1'b1;
        alu_rd = 5'd5;
        alu_data = 32'h1234;
        #1;
        check("single_alu_ready", 32'(alu_ready), 1);
        check("single_mem_ready", 32'(mem_ready), 0);
        step();
        alu_valid = 1'b0;
        check("single_rf_write", 32'(rf_write), 1);
        check("single_rf_addr", 32'(rf_c_address), 5);
        check("single_rf_in", rf_c_in, 32'h1234);
        step();
        check("single_rf_idle", 32'(rf_write), 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        alu_valid = 1'b1;
        mem_valid = 1'b1;
        alu_rd = 5'd1;
        alu_data = 32'hA1;
        mem_rd = 5'd2;
        mem_data = 32'hB2;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_alu_ready", 32'(alu_ready), 32'(i % 2 == 0));
            check("rr_mem_ready", 32'(mem_ready), 32'(i % 2 == 1));
            step();
            check("rr_rf_write", 32'(rf_write), 1);
            check("rr_rf_addr", 32'(rf_c_address), (i % 2 == 0) ? 1 : 2);
            check("rr_rf_in", rf_c_in, (i % 2 == 0) ? 32'hA1 : 32'hB2);
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        step();
        check("rr_rf_idle", 32'(rf_write), 0);
        issue_valid = 1'b1;
        issue_rd = 5'd7;
        step();
        issue_valid = 1'b0;
        a_address = 5'd7;
        #1;
        check("sb_busy_set", 32'(a_busy), 1);
        step();
        check("sb_busy_hold", 32'(a_busy), 1);
        mem_valid = 1'b1;
        mem_rd = 5'd7;
        mem_data = 32'hCAFE;
        #1;
        check("sb_mem_ready", 32'(mem_ready), 1);
        check("sb_busy_xfer", 32'(a_busy), 1);
        step();
        mem_valid = 1'b0;
        #1;
        check("sb_rf_write", 32'(rf_write), 1);
        check("sb_rf_addr", 32'(rf_c_address), 7);
        check("sb_busy_wb", 32'(a_busy), 32'(!BYP));
        check("sb_fwd_a_valid", 32'(fwd_a_valid), 32'(BYP));
        check("sb_fwd_a_data", fwd_a_data, BYP ? 32'hCAFE : 32'h0);
        check("sb_fwd_b_valid", 32'(fwd_b_valid), 0);
        step();
        check("sb_busy_clear", 32'(a_busy), 0);
        alu_valid = 1'b1;
        alu_rd = 5'd0;
        alu_data = 32'hFFFF_FFFF;
        a_address = 5'd0;
        #1;
        check("r0_alu_ready", 32'(alu_ready), 1);
        step();
        alu_valid = 1'b0;
        #1;
        check("r0_rf_write", 32'(rf_write), 0);
        check("r0_a_busy", 32'(a_busy), 0);
        check("r0_fwd_a", 32'(fwd_a_valid), 0);
        issue_valid = 1'b1;
        issue_rd = 5'd3;
        alu_valid = 1'b1;
        alu_rd = 5'd3;
        alu_data = 32'h33;
        b_address = 5'd3;
        #1;
        check("sw_alu_ready", 32'(alu_ready), 1);
        step();
        issue_valid = 1'b0;
        alu_valid = 1'b0;
        #1;
        check("sw_b_busy_wb", 32'(b_busy), 1);
        step();
        check("sw_b_busy_after", 32'(b_busy), 1);
        mem_valid = 1'b1;
        mem_rd = 5'd3;
        mem_data = 32'h3;
        step();
        mem_valid = 1'b0;
        step();
        check("sw_b_busy_cleared", 32'(b_busy), 0);
        issue_valid = 1'b1;
        issue_rd = 5'd4;
        step();
        issue_valid = 1'b0;
        alu_valid = 1'b1;
        alu_rd = 5'd9;
        alu_data = 32'h99;
        a_address = 5'd4;
        b_address = 5'd9;
        #1;
        check("rd_alu_ready", 32'(alu_ready), 1);
        step();
        reset = 1'b1;
        #1;
        check("rd_rf_write_rst", 32'(rf_write), 0);
        check("rd_alu_ready_rst", 32'(alu_ready), 0);
        step();
        reset = 1'b0;
        alu_valid = 1'b0;
        #1;
        check("rd_rf_write_after", 32'(rf_write), 0);
        check("rd_a_busy", 32'(a_busy), 0);
        check("rd_b_busy", 32'(b_busy), 0);
        check("rd_rf_addr", 32'(rf_c_address), 0);
        step();
        check("rd_rf_write_late", 32'(rf_write), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
